// File: rtl/avl_master_bc.sv
// Single-outstanding Avalon-MM master: turns level-held bus_* requests into read/write cycles.
// Optional waitrequest watchdog is enabled by defining AVL_TIMEOUT_EN.
module avl_master_bc #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  // Avalon-MM side
  input  logic [31:0] avl_readdata_i,
  input  logic        avl_waitrequest_i,
  output logic [31:0] avl_address_o,
  output logic [3:0]  avl_byteenable_o,
  output logic [31:0] avl_writedata_o,
  output logic        avl_read_o,
  output logic        avl_write_o,
  // Arbiter side
  input  logic [31:0] bus_address_i,
  input  logic [31:0] bus_writedata_i,
  input  logic [3:0]  bus_byteenable_i,
  input  logic        bus_read_i,
  input  logic        bus_write_i,
  output logic [31:0] bus_readdata_o,
  output logic        bus_busy_o
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e      state_q;
  logic [31:0] avl_address_q;
  logic [3:0]  avl_byteenable_q;
  logic [31:0] avl_writedata_q;
  logic        avl_read_q;
  logic        avl_write_q;
  logic [31:0] bus_readdata_q;
  logic        req_valid;

  // Read and write together is malformed and never starts a transfer.
  assign req_valid = bus_read_i ^ bus_write_i;

`ifdef AVL_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] tmo_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      avl_address_q    <= '0;
      avl_byteenable_q <= '0;
      avl_writedata_q  <= '0;
      avl_read_q       <= 1'b0;
      avl_write_q      <= 1'b0;
      bus_readdata_q   <= '0;
`ifdef AVL_TIMEOUT_EN
      tmo_cnt_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            avl_address_q    <= bus_address_i;
            avl_byteenable_q <= bus_byteenable_i;
            avl_writedata_q  <= bus_writedata_i;
            avl_read_q       <= bus_read_i;
            avl_write_q      <= bus_write_i;
            state_q          <= StActive;
`ifdef AVL_TIMEOUT_EN
            tmo_cnt_q        <= '0;
`endif
          end
        end
        StActive: begin
          if (!avl_waitrequest_i) begin
            if (avl_read_q) begin
              bus_readdata_q <= avl_readdata_i;
            end
            avl_read_q  <= 1'b0;
            avl_write_q <= 1'b0;
            state_q     <= StIdle;
          end
`ifdef AVL_TIMEOUT_EN
          // Abort on the edge that would make the stall count reach TIMEOUT_CYCLES.
          else if (tmo_cnt_q == TmoLast) begin
            if (avl_read_q) begin
              bus_readdata_q <= 32'hFFFF_FFFF;
            end
            avl_read_q  <= 1'b0;
            avl_write_q <= 1'b0;
            state_q     <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign avl_address_o    = avl_address_q;
  assign avl_byteenable_o = avl_byteenable_q;
  assign avl_writedata_o  = avl_writedata_q;
  assign avl_read_o       = avl_read_q;
  assign avl_write_o      = avl_write_q;
  assign bus_readdata_o   = bus_readdata_q;
  assign bus_busy_o       = (state_q == StActive);

endmodule

// File: tb/tb_avl_master_bc.sv
// Directed self-checking bench for avl_master_bc; checks sampled 1ns after each rising edge.
module tb_avl_master_bc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;
  logic [31:0] avl_address;
  logic [3:0]  avl_byteenable;
  logic [31:0] avl_writedata;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] bus_address;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_readdata;
  logic        bus_busy;

  int errors = 0;
  int checks = 0;

  avl_master_bc #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .avl_readdata_i    (avl_readdata),
    .avl_waitrequest_i (avl_waitrequest),
    .avl_address_o     (avl_address),
    .avl_byteenable_o  (avl_byteenable),
    .avl_writedata_o   (avl_writedata),
    .avl_read_o        (avl_read),
    .avl_write_o       (avl_write),
    .bus_address_i     (bus_address),
    .bus_writedata_i   (bus_writedata),
    .bus_byteenable_i  (bus_byteenable),
    .bus_read_i        (bus_read),
    .bus_write_i       (bus_write),
    .bus_readdata_o    (bus_readdata),
    .bus_busy_o        (bus_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    avl_readdata    = 32'h0;
    avl_waitrequest = 1'b0;
    bus_address     = 32'h0;
    bus_writedata   = 32'h0;
    bus_byteenable  = 4'h0;
    bus_read        = 1'b0;
    bus_write       = 1'b0;
    tick();
    tick();
    check("rst_read", {31'b0, avl_read}, 32'h0);
    check("rst_write", {31'b0, avl_write}, 32'h0);
    check("rst_busy", {31'b0, bus_busy}, 32'h0);
    check("rst_addr", avl_address, 32'h0);
    check("rst_rdata", bus_readdata, 32'h0);

    // Reset with a read in flight; the completing data must not be captured.
    rst             = 1'b0;
    bus_read        = 1'b1;
    bus_address     = 32'h0000_0044;
    bus_byteenable  = 4'hF;
    avl_waitrequest = 1'b1;
    tick();
    check("inflight_read", {31'b0, avl_read}, 32'h1);
    check("inflight_busy", {31'b0, bus_busy}, 32'h1);
    rst             = 1'b1;
    bus_read        = 1'b0;
    avl_waitrequest = 1'b0;
    avl_readdata    = 32'hAAAA_5555;
    tick();
    check("midrst_read", {31'b0, avl_read}, 32'h0);
    check("midrst_busy", {31'b0, bus_busy}, 32'h0);
    check("midrst_rdata", bus_readdata, 32'h0);
    check("midrst_be", {28'b0, avl_byteenable}, 32'h0);
    check("midrst_addr", avl_address, 32'h0);
    rst = 1'b0;
    tick();

    // Zero-wait read
    bus_read       = 1'b1;
    bus_address    = 32'hBFC0_0000;
    bus_byteenable = 4'hF;
    avl_readdata   = 32'h1234_5678;
    tick();
    bus_read = 1'b0;
    check("zw_read", {31'b0, avl_read}, 32'h1);
    check("zw_addr", avl_address, 32'hBFC0_0000);
    check("zw_busy", {31'b0, bus_busy}, 32'h1);
    tick();
    check("zw_read_drop", {31'b0, avl_read}, 32'h0);
    check("zw_busy_drop", {31'b0, bus_busy}, 32'h0);
    check("zw_rdata", bus_readdata, 32'h1234_5678);
    tick();
    check("zw_no_repeat", {31'b0, avl_read}, 32'h0);

    // Wait-state write with the request inputs changing mid-transfer
    bus_write       = 1'b1;
    bus_address     = 32'h0000_1000;
    bus_writedata   = 32'hDEAD_BEEF;
    bus_byteenable  = 4'b0011;
    avl_waitrequest = 1'b1;
    avl_readdata    = 32'hCAFE_0001;
    tick();
    bus_write      = 1'b0;
    bus_address    = 32'h0000_2000;
    bus_writedata  = 32'h0;
    bus_byteenable = 4'hF;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ws_write%0d", k), {31'b0, avl_write}, 32'h1);
      check($sformatf("ws_addr%0d", k), avl_address, 32'h0000_1000);
      check($sformatf("ws_wdata%0d", k), avl_writedata, 32'hDEAD_BEEF);
      check($sformatf("ws_be%0d", k), {28'b0, avl_byteenable}, 32'h3);
      check($sformatf("ws_busy%0d", k), {31'b0, bus_busy}, 32'h1);
      if (k == 3) avl_waitrequest = 1'b0;
      tick();
    end
    check("ws_write_drop", {31'b0, avl_write}, 32'h0);
    check("ws_busy_drop", {31'b0, bus_busy}, 32'h0);
    check("ws_rdata_kept", bus_readdata, 32'h1234_5678);

    // Read and write together is ignored
    bus_read  = 1'b1;
    bus_write = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("both_read%0d", k), {31'b0, avl_read}, 32'h0);
      check($sformatf("both_write%0d", k), {31'b0, avl_write}, 32'h0);
      check($sformatf("both_busy%0d", k), {31'b0, bus_busy}, 32'h0);
    end
    bus_write = 1'b0;

    // Held read request: two pulses separated by an idle cycle
    bus_address  = 32'h0000_0300;
    avl_readdata = 32'h0BAD_F00D;
    tick();
    check("held_p1", {31'b0, avl_read}, 32'h1);
    check("held_p1_addr", avl_address, 32'h0000_0300);
    tick();
    check("held_gap_read", {31'b0, avl_read}, 32'h0);
    check("held_gap_busy", {31'b0, bus_busy}, 32'h0);
    check("held_rdata1", bus_readdata, 32'h0BAD_F00D);
    avl_readdata = 32'h55AA_55AA;
    tick();
    check("held_p2", {31'b0, avl_read}, 32'h1);
    bus_read = 1'b0;
    tick();
    check("held_p2_drop", {31'b0, avl_read}, 32'h0);
    check("held_rdata2", bus_readdata, 32'h55AA_55AA);

    // Stuck waitrequest
    bus_read        = 1'b1;
    bus_address     = 32'h0000_0500;
    avl_waitrequest = 1'b1;
    tick();
    bus_read = 1'b0;
`ifdef AVL_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tmo_read%0d", k), {31'b0, avl_read}, 32'h1);
      tick();
    end
    check("tmo_read_drop", {31'b0, avl_read}, 32'h0);
    check("tmo_busy_drop", {31'b0, bus_busy}, 32'h0);
    check("tmo_rdata", bus_readdata, 32'hFFFF_FFFF);
`else
    for (int k = 0; k < 20; k++) tick();
    check("stall_read", {31'b0, avl_read}, 32'h1);
    check("stall_busy", {31'b0, bus_busy}, 32'h1);
    check("stall_rdata", bus_readdata, 32'h55AA_55AA);
    avl_readdata    = 32'h7777_0000;
    avl_waitrequest = 1'b0;
    tick();
    check("stall_done", {31'b0, bus_busy}, 32'h0);
    check("stall_rdata2", bus_readdata, 32'h7777_0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
